// File: rtl/sd_dat_tx.sv
// sd_dat_tx: SD write-direction DAT engine. Streams 32-bit FIFO words as framed 4-bit
// blocks with per-line CRC16, then checks the card's CRC status token and waits out busy.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | waiting for a FIFO word, strobes tx_buf_rd
// LOAD      | FIFO data valid, load shift register, clear CRCs
// START     | drive start bit (4'h0)
// DATA      | shift one nibble per cycle, prefetch next word at nibble 6
// CRC       | shift out 16 CRC bits per line, MSB first
// END       | drive end bit (4'hF)
// ST_WAIT   | bus released, waiting for status start bit on DAT0
// STATUS    | sample 3 status bits and the end bit
// BUSYW     | waiting for card to release DAT0
// FIN       | pulse done, return to IDLE
module sd_dat_tx #(
   parameter int BUSY_TIMEOUT = 1024
) (
   input  logic        CLK,
   input  logic        rst_L,
   input  logic        start,
   input  logic [11:0] block_size,
   input  logic [15:0] block_count,
   input  logic [31:0] tx_buf_dout,
   input  logic        tx_buf_empty,
   output logic        tx_buf_rd,
   input  logic [3:0]  dat_in,
   output logic [3:0]  dat_out,
   output logic        dat_oe,
   output logic        busy,
   output logic        done,
   output logic [15:0] blocks_done,
   output logic        crc_status_err,
   output logic        timeout_err,
   output logic        underrun_err
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_CRC,
      S_END, S_ST_WAIT, S_STATUS, S_BUSYW, S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [31:0]       shift_q, shift_d;
   logic [3:0][15:0]  crc_q, crc_d;
   logic [3:0]        nib_q, nib_d;
   logic [9:0]        words_q, words_d;
   logic [9:0]        wrd_rem_q, wrd_rem_d;
   logic [15:0]       blk_rem_q, blk_rem_d;
   logic [2:0]        sts_q, sts_d;
   logic [TW-1:0]     to_q, to_d;
   logic [15:0]       blocks_done_q, blocks_done_d;
   logic              crc_err_q, crc_err_d;
   logic              to_err_q, to_err_d;
   logic              und_err_q, und_err_d;

   logic              unused_ok;
   assign unused_ok = ^{dat_in[3:1], block_size[1:0]};

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   always_ff @(posedge CLK) begin
      if (!rst_L) begin
         state_q       <= S_IDLE;
         shift_q       <= '0;
         crc_q         <= '0;
         nib_q         <= '0;
         words_q       <= '0;
         wrd_rem_q     <= '0;
         blk_rem_q     <= '0;
         sts_q         <= '0;
         to_q          <= '0;
         blocks_done_q <= '0;
         crc_err_q     <= 1'b0;
         to_err_q      <= 1'b0;
         und_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         crc_q         <= crc_d;
         nib_q         <= nib_d;
         words_q       <= words_d;
         wrd_rem_q     <= wrd_rem_d;
         blk_rem_q     <= blk_rem_d;
         sts_q         <= sts_d;
         to_q          <= to_d;
         blocks_done_q <= blocks_done_d;
         crc_err_q     <= crc_err_d;
         to_err_q      <= to_err_d;
         und_err_q     <= und_err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      crc_d         = crc_q;
      nib_d         = nib_q;
      words_d       = words_q;
      wrd_rem_d     = wrd_rem_q;
      blk_rem_d     = blk_rem_q;
      sts_d         = sts_q;
      to_d          = to_q;
      blocks_done_d = blocks_done_q;
      crc_err_d     = crc_err_q;
      to_err_d      = to_err_q;
      und_err_d     = und_err_q;
      tx_buf_rd     = 1'b0;
      dat_out       = 4'hF;
      dat_oe        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               words_d       = block_size[11:2];
               blk_rem_d     = block_count;
               blocks_done_d = '0;
               crc_err_d     = 1'b0;
               to_err_d      = 1'b0;
               und_err_d     = 1'b0;
               if (block_count == 16'd0 || block_size[11:2] == 10'd0) state_d = S_FIN;
               else                                                   state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!tx_buf_empty) begin
               tx_buf_rd = 1'b1;
               state_d   = S_LOAD;
            end
         end
         S_LOAD: begin
            shift_d   = tx_buf_dout;
            nib_d     = '0;
            wrd_rem_d = words_q;
            crc_d     = '0;
            state_d   = S_START;
         end
         S_START: begin
            dat_oe  = 1'b1;
            dat_out = 4'h0;
            state_d = S_DATA;
         end
         S_DATA: begin
            dat_oe  = 1'b1;
            dat_out = shift_q[31:28];
            for (int i = 0; i < 4; i++) crc_d[i] = crc16_step(crc_q[i], shift_q[28+i]);
            shift_d = {shift_q[27:0], 4'h0};
            nib_d   = nib_q + 4'd1;
            // Prefetch at nibble 6 so the next word is on tx_buf_dout during nibble 7.
            if (nib_q == 4'd6 && wrd_rem_q != 10'd1) begin
               if (!tx_buf_empty) begin
                  tx_buf_rd = 1'b1;
               end else begin
                  und_err_d = 1'b1;
                  state_d   = S_FIN;
               end
            end
            if (nib_q == 4'd7) begin
               nib_d = '0;
               if (wrd_rem_q == 10'd1) begin
                  state_d = S_CRC;
               end else begin
                  shift_d   = tx_buf_dout;
                  wrd_rem_d = wrd_rem_q - 10'd1;
               end
            end
         end
         S_CRC: begin
            dat_oe = 1'b1;
            for (int i = 0; i < 4; i++) begin
               dat_out[i] = crc_q[i][15];
               crc_d[i]   = {crc_q[i][14:0], 1'b0};
            end
            nib_d = nib_q + 4'd1;
            if (nib_q == 4'd15) state_d = S_END;
         end
         S_END: begin
            dat_oe  = 1'b1;
            dat_out = 4'hF;
            to_d    = TW'(1);
            state_d = S_ST_WAIT;
         end
         S_ST_WAIT: begin
            to_d = to_q + TW'(1);
            if (!dat_in[0]) begin
               nib_d   = '0;
               state_d = S_STATUS;
            end
         end
         S_STATUS: begin
            to_d  = to_q + TW'(1);
            nib_d = nib_q + 4'd1;
            if (nib_q < 4'd3) begin
               sts_d = {sts_q[1:0], dat_in[0]};
            end else if (sts_q == 3'b010 && dat_in[0]) begin
               blocks_done_d = blocks_done_q + 16'd1;
               state_d       = S_BUSYW;
            end else begin
               crc_err_d = 1'b1;
               state_d   = S_FIN;
            end
         end
         S_BUSYW: begin
            to_d = to_q + TW'(1);
            if (dat_in[0]) begin
               if (blk_rem_q == 16'd1) begin
                  state_d = S_FIN;
               end else begin
                  blk_rem_d = blk_rem_q - 16'd1;
                  state_d   = S_FETCH;
               end
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // One budget covers status wait, status bits and busy; it overrides any other exit.
      if ((state_q == S_ST_WAIT || state_q == S_STATUS || state_q == S_BUSYW) &&
          to_d == TW'(BUSY_TIMEOUT)) begin
         to_err_d = 1'b1;
         state_d  = S_FIN;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_FIN);
   assign blocks_done    = blocks_done_q;
   assign crc_status_err = crc_err_q;
   assign timeout_err    = to_err_q;
   assign underrun_err   = und_err_q;

endmodule

// File: tb/tb_sd_dat_tx.sv
// tb_sd_dat_tx: directed bench for sd_dat_tx with a FIFO model, a scripted card on DAT0
// and a reference per-line CRC16 used to build the expected bus stream.
module tb_sd_dat_tx;

   logic        CLK = 1'b0;
   logic        rst_L;
   logic        start;
   logic [11:0] block_size;
   logic [15:0] block_count;
   logic [31:0] tx_buf_dout = 32'h0;
   logic        tx_buf_empty;
   logic        tx_buf_rd;
   logic [3:0]  dat_in;
   logic [3:0]  dat_out;
   logic        dat_oe;
   logic        busy;
   logic        done;
   logic [15:0] blocks_done;
   logic        crc_status_err;
   logic        timeout_err;
   logic        underrun_err;

   always #5 CLK = ~CLK;

   sd_dat_tx #(.BUSY_TIMEOUT(16)) dut (
      .CLK            (CLK),
      .rst_L          (rst_L),
      .start          (start),
      .block_size     (block_size),
      .block_count    (block_count),
      .tx_buf_dout    (tx_buf_dout),
      .tx_buf_empty   (tx_buf_empty),
      .tx_buf_rd      (tx_buf_rd),
      .dat_in         (dat_in),
      .dat_out        (dat_out),
      .dat_oe         (dat_oe),
      .busy           (busy),
      .done           (done),
      .blocks_done    (blocks_done),
      .crc_status_err (crc_status_err),
      .timeout_err    (timeout_err),
      .underrun_err   (underrun_err)
   );

   int          total = 0;
   int          bad = 0;
   logic [31:0] mem [16];
   int          rp = 0;
   int          wp = 0;
   logic        flush = 1'b0;
   logic        card_seq[$];
   logic        card_idle = 1'b1;
   logic [31:0] wq[$];
   logic [3:0]  nib_log[$];
   logic [3:0]  exp_q[$];
   int          oe_cyc[$];
   int          rd_cyc[$];
   int          done_n;
   int          done_cyc;
   int          busy_post;
   logic [15:0] bd_done;
   logic [2:0]  err_done;

   // FIFO model: data appears the cycle after the read strobe.
   assign tx_buf_empty = (rp == wp);
   always @(posedge CLK) begin
      if (flush) begin
         rp <= wp;
      end else if (tx_buf_rd) begin
         tx_buf_dout <= mem[rp[3:0]];
         rp          <= rp + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic [15:0] r;
      r = c << 1;
      if (c[15] ^ b) r = r ^ 16'h1021;
      return r;
   endfunction

   task automatic load_words();
      foreach (wq[i]) begin
         mem[wp[3:0]] = wq[i];
         wp = wp + 1;
      end
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
   endtask

   // Expected bus nibbles while dat_oe=1: start, data, CRC, end per block.
   task automatic build_exp(input int nw, input int nb);
      logic [15:0] c [4];
      logic [31:0] w;
      logic [3:0]  n;
      exp_q.delete();
      for (int b = 0; b < nb; b++) begin
         for (int l = 0; l < 4; l++) c[l] = 16'h0;
         exp_q.push_back(4'h0);
         for (int k = 0; k < nw; k++) begin
            w = wq[b*nw + k];
            for (int j = 0; j < 8; j++) begin
               n = 4'(w >> (28 - 4*j));
               exp_q.push_back(n);
               for (int l = 0; l < 4; l++) c[l] = crc_bit(c[l], n[l]);
            end
         end
         for (int j = 0; j < 16; j++)
            exp_q.push_back({c[3][15-j], c[2][15-j], c[1][15-j], c[0][15-j]});
         exp_q.push_back(4'hF);
      end
   endtask

   task automatic cmp_stream(input string tag);
      int n;
      check({tag, "_len"}, nib_log.size(), exp_q.size());
      n = (nib_log.size() < exp_q.size()) ? nib_log.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_nib%0d", tag, i), 32'(nib_log[i]), 32'(exp_q[i]));
   endtask

   // Cycle 0 is the cycle start is high; samples are taken at each following negedge.
   task automatic run(input logic [11:0] bs, input logic [15:0] bc, input logic poke_fin);
      int cpos;
      int after;
      logic oe_prev;
      nib_log.delete();
      oe_cyc.delete();
      rd_cyc.delete();
      done_n    = 0;
      done_cyc  = -10;
      busy_post = -1;
      cpos      = 1000;
      after     = -1;
      oe_prev   = 1'b0;
      block_size  = bs;
      block_count = bc;
      start       = 1'b1;
      for (int c = 1; c < 400 && after != 0; c++) begin
         @(negedge CLK);
         start = 1'b0;
         if (after > 0) after--;
         if (dat_oe) begin
            nib_log.push_back(dat_out);
            oe_cyc.push_back(c);
         end
         if (tx_buf_rd) rd_cyc.push_back(c);
         if (c == done_cyc + 1) busy_post = int'(busy);
         if (done) begin
            done_n++;
            done_cyc = c;
            bd_done  = blocks_done;
            err_done = {crc_status_err, timeout_err, underrun_err};
            after    = 4;
            if (poke_fin) begin
               block_count = 16'd1;
               start       = 1'b1;
            end
         end
         if (oe_prev && !dat_oe) cpos = 0;
         if (cpos < card_seq.size()) begin
            dat_in = {3'b111, card_seq[cpos]};
            cpos++;
         end else begin
            dat_in = {3'b111, card_idle};
         end
         oe_prev = dat_oe;
      end
      start = 1'b0;
      check("done_pulses", done_n, 1);
   endtask

   initial begin
      logic [31:0] v;
      rst_L = 1'b0;
      start = 1'b0;
      block_size = '0;
      block_count = '0;
      dat_in = 4'hF;
      repeat (3) @(negedge CLK);
      check("reset_outs", 32'({dat_out, dat_oe, tx_buf_rd, busy, done, blocks_done,
                               crc_status_err, timeout_err, underrun_err}), 32'({4'hF, 23'h0}));
      rst_L = 1'b1;
      @(negedge CLK);

      // single zero block, start poked during FIN must be ignored
      wq = '{32'h0000_0000};
      load_words();
      card_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      card_idle = 1'b1;
      run(12'd4, 16'd1, 1'b1);
      build_exp(1, 1);
      cmp_stream("t1");
      check("t1_start_cyc", oe_cyc[0], 3);
      check("t1_rd_cnt", rd_cyc.size(), 1);
      check("t1_rd_cyc", rd_cyc[0], 1);
      check("t1_done_cyc", done_cyc, 40);
      check("t1_blocks", 32'(bd_done), 1);
      check("t1_errs", 32'(err_done), 0);
      check("t1_fin_start_ignored", busy_post, 0);

      // nibble order and per-line CRC
      wq = '{32'h1234_5678};
      load_words();
      run(12'd4, 16'd1, 1'b0);
      v = 0;
      for (int k = 1; k <= 8; k++) v = (v << 4) | 32'(nib_log[k]);
      check("t2_order", v, 32'h1234_5678);
      build_exp(1, 1);
      cmp_stream("t2");

      // three back-to-back blocks of two words
      wq = '{32'hA1B2_C3D4, 32'h0F1E_2D3C, 32'h5566_7788, 32'hDEAD_BEEF, 32'h8000_0001, 32'hFFFF_0000};
      load_words();
      run(12'd8, 16'd3, 1'b0);
      build_exp(2, 3);
      cmp_stream("t3");
      check("t3_rd_cnt", rd_cyc.size(), 6);
      check("t3_rd1", rd_cyc[1], 10);
      check("t3_rd2", rd_cyc[2], 48);
      check("t3_rd3", rd_cyc[3], 57);
      if (oe_cyc.size() >= 102)
         for (int b = 0; b < 3; b++)
            check($sformatf("t3_span%0d", b), oe_cyc[b*34+33] - oe_cyc[b*34], 33);
      check("t3_done_cyc", done_cyc, 142);
      check("t3_blocks", 32'(bd_done), 3);

      // negative status on first of two blocks
      wq = '{32'h1111_1111, 32'h2222_2222};
      load_words();
      card_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      run(12'd4, 16'd2, 1'b0);
      check("t4_errs", 32'(err_done), 32'b100);
      check("t4_blocks", 32'(bd_done), 0);
      check("t4_one_block", nib_log.size(), 26);
      check("t4_done_cyc", done_cyc, 34);
      check("t4_sticky", 32'(crc_status_err), 1);
      do_flush();

      // card holds DAT0 busy forever after a good status
      wq = '{32'hCAFE_F00D};
      load_words();
      card_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      card_idle = 1'b0;
      run(12'd4, 16'd1, 1'b0);
      card_idle = 1'b1;
      check("t5_errs", 32'(err_done), 32'b010);
      check("t5_done_cyc", done_cyc, 44);
      check("t5_end2done", done_cyc - oe_cyc[oe_cyc.size()-1], 16);
      check("t5_blocks", 32'(bd_done), 1);

      // underrun: one word for a two-word block
      wq = '{32'h9876_5432};
      load_words();
      card_seq.delete();
      run(12'd8, 16'd1, 1'b0);
      check("t6_errs", 32'(err_done), 32'b001);
      check("t6_oe_len", nib_log.size(), 8);
      check("t6_last_oe", oe_cyc[oe_cyc.size()-1], 10);
      check("t6_done_cyc", done_cyc, 11);

      // reset during DATA
      wq = '{32'h1357_9BDF, 32'h2468_ACE0};
      load_words();
      block_size = 12'd8;
      block_count = 16'd1;
      start = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         start = 1'b0;
      end
      check("t7_pre_rst", 32'({busy, dat_oe}), 32'h3);
      rst_L = 1'b0;
      @(negedge CLK);
      check("t7_rst_outs", 32'({dat_out, dat_oe, tx_buf_rd, busy, done, blocks_done,
                                crc_status_err, timeout_err, underrun_err}), 32'({4'hF, 23'h0}));
      rst_L = 1'b1;
      done_n = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge CLK);
         if (done) done_n++;
      end
      check("t7_no_done", done_n, 0);
      check("t7_idle", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
